// File: rtl/button_conditioner.sv
// button_conditioner
//   Conditions the raw DE1-SoC KEY pads for the buttons PIO and fabric logic.
//   Each channel has a 2-flop synchronizer, a counter debounce, and registered
//   press / release / long-press strobes. Channels are fully independent.
//
//   Optional feature macro: BTN_AUTO_REPEAT_EN
//     defined   : repeat_pulse strobes every REPEAT_CYCLES after a long press
//     undefined : no repeat counter is built and repeat_pulse is tied to 0
//
//   Reset is synchronous and active-low. It clears every flop, including the
//   synchronizer, so a key held through reset is seen as a brand-new press.

module button_conditioner #(
  parameter int NUM_BUTTONS     = 3,
  parameter int ACTIVE_LOW      = 1,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int LONG_CYCLES     = 50_000_000,
  parameter int REPEAT_CYCLES   = 10_000_000
) (
  input  logic                   clk_clk,
  input  logic                   reset_reset_n,
  input  logic [NUM_BUTTONS-1:0] key_raw,
  output logic [NUM_BUTTONS-1:0] buttons_export,
  output logic [NUM_BUTTONS-1:0] press_pulse,
  output logic [NUM_BUTTONS-1:0] release_pulse,
  output logic [NUM_BUTTONS-1:0] long_pulse,
  output logic [NUM_BUTTONS-1:0] repeat_pulse
);

  // Debounce counter only ever reaches DEBOUNCE_CYCLES-1 before it clears.
  localparam int DB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  // Hold counter saturates at LONG_CYCLES, so it needs room for that value.
  localparam int HOLD_W = $clog2(LONG_CYCLES + 1);

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_SAT  = HOLD_W'(LONG_CYCLES);

  // XOR mask that turns the pad level into "1 = pressed".
  localparam logic [NUM_BUTTONS-1:0] POL_MASK = (ACTIVE_LOW != 0) ? '1 : '0;

  // Counters rely on a terminal count distinct from the cleared value.
  if (DEBOUNCE_CYCLES < 2 || LONG_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_param_check
    $error("button_conditioner: DEBOUNCE_CYCLES, LONG_CYCLES and REPEAT_CYCLES must be >= 2");
  end

`ifdef BTN_AUTO_REPEAT_EN
  // Repeat counter runs 0 .. REPEAT_CYCLES-1 and wraps only via explicit clear.
  localparam int REP_W = (REPEAT_CYCLES > 2) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);
`endif

  // Polarity-normalized synchronizer; reset parks both stages at "released".
  logic [NUM_BUTTONS-1:0] s1_q;
  logic [NUM_BUTTONS-1:0] s2_q;

  // Two-flop synchronizer for the asynchronous pads.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= key_raw ^ POL_MASK;
      s2_q <= s1_q;
    end
  end

  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_ch
    logic              stable_q;
    logic              stable_d;
    logic [DB_W-1:0]   db_cnt_q;
    logic [DB_W-1:0]   db_cnt_d;
    logic [HOLD_W-1:0] hold_cnt_q;
    logic [HOLD_W-1:0] hold_cnt_d;
    logic              press_q;
    logic              press_d;
    logic              release_q;
    logic              release_d;
    logic              long_q;
    logic              long_d;

    // Debounce: accept the synchronized level once it has differed from the
    // stable level for DEBOUNCE_CYCLES consecutive samples.
    always_comb begin
      stable_d  = stable_q;
      db_cnt_d  = db_cnt_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      if (s2_q[i] == stable_q) begin
        db_cnt_d = '0;
      end else if (db_cnt_q == DB_LAST) begin
        stable_d  = s2_q[i];
        db_cnt_d  = '0;
        press_d   = s2_q[i];
        release_d = ~s2_q[i];
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end

    // Hold timer: counts cycles spent pressed, fires long_pulse once and then
    // sits at LONG_CYCLES, which also marks "long press reached" for repeat.
    // A release accepted on this edge suppresses any long strobe.
    always_comb begin
      hold_cnt_d = hold_cnt_q;
      long_d     = 1'b0;
      if (!stable_q || release_d) begin
        hold_cnt_d = '0;
      end else if (hold_cnt_q == HOLD_LAST) begin
        hold_cnt_d = HOLD_SAT;
        long_d     = 1'b1;
      end else if (hold_cnt_q != HOLD_SAT) begin
        hold_cnt_d = hold_cnt_q + 1'b1;
      end
    end

    // Channel state and registered strobes.
    always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) begin
        stable_q   <= 1'b0;
        db_cnt_q   <= '0;
        hold_cnt_q <= '0;
        press_q    <= 1'b0;
        release_q  <= 1'b0;
        long_q     <= 1'b0;
      end else begin
        stable_q   <= stable_d;
        db_cnt_q   <= db_cnt_d;
        hold_cnt_q <= hold_cnt_d;
        press_q    <= press_d;
        release_q  <= release_d;
        long_q     <= long_d;
      end
    end

    assign buttons_export[i] = stable_q;
    assign press_pulse[i]    = press_q;
    assign release_pulse[i]  = release_q;
    assign long_pulse[i]     = long_q;

`ifdef BTN_AUTO_REPEAT_EN
    logic [REP_W-1:0] rep_cnt_q;
    logic [REP_W-1:0] rep_cnt_d;
    logic             repeat_q;
    logic             repeat_d;

    // Auto-repeat: restarts on the long_pulse edge, then strobes every
    // REPEAT_CYCLES while held; release (or not pressed) clears it.
    always_comb begin
      rep_cnt_d = rep_cnt_q;
      repeat_d  = 1'b0;
      if (!stable_q || release_d || long_d) begin
        rep_cnt_d = '0;
      end else if (hold_cnt_q == HOLD_SAT) begin
        if (rep_cnt_q == REP_LAST) begin
          rep_cnt_d = '0;
          repeat_d  = 1'b1;
        end else begin
          rep_cnt_d = rep_cnt_q + 1'b1;
        end
      end
    end

    // Repeat counter and registered repeat strobe.
    always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) begin
        rep_cnt_q <= '0;
        repeat_q  <= 1'b0;
      end else begin
        rep_cnt_q <= rep_cnt_d;
        repeat_q  <= repeat_d;
      end
    end

    assign repeat_pulse[i] = repeat_q;
`else
    assign repeat_pulse[i] = 1'b0;
`endif
  end

endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner
//   Directed bench for button_conditioner with DEBOUNCE_CYCLES=8,
//   LONG_CYCLES=40, REPEAT_CYCLES=10, ACTIVE_LOW=1. Repeat expectations follow
//   the BTN_AUTO_REPEAT_EN macro of the build.

module tb_button_conditioner;

  localparam int NB = 3;
  localparam int DB = 8;
  localparam int LG = 40;
  localparam int RP = 10;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NB-1:0] key;
  logic [NB-1:0] btn;
  logic [NB-1:0] prs;
  logic [NB-1:0] rel;
  logic [NB-1:0] lng;
  logic [NB-1:0] rpt;

  always #5 clk = ~clk;

  button_conditioner #(
    .NUM_BUTTONS    (NB),
    .ACTIVE_LOW     (1),
    .DEBOUNCE_CYCLES(DB),
    .LONG_CYCLES    (LG),
    .REPEAT_CYCLES  (RP)
  ) dut (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
    .key_raw       (key),
    .buttons_export(btn),
    .press_pulse   (prs),
    .release_pulse (rel),
    .long_pulse    (lng),
    .repeat_pulse  (rpt)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int n_press[NB];
  int n_rel[NB];
  int n_long[NB];
  int n_rep[NB];
  int t_press[NB];
  int t_rel[NB];
  int t_long[NB];
  int rep_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    for (int i = 0; i < NB; i++) begin
      n_press[i] = 0; n_rel[i] = 0; n_long[i] = 0; n_rep[i] = 0;
      t_press[i] = -1; t_rel[i] = -1; t_long[i] = -1;
    end
    rep_q.delete();
  endtask

  // One clock: advance past the edge, then log every strobe with its cycle.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < NB; i++) begin
      if (prs[i] === 1'b1) begin n_press[i]++; t_press[i] = cyc; end
      if (rel[i] === 1'b1) begin n_rel[i]++;   t_rel[i]   = cyc; end
      if (lng[i] === 1'b1) begin n_long[i]++;  t_long[i]  = cyc; end
      if (rpt[i] === 1'b1) begin
        n_rep[i]++;
        if (i == 2) rep_q.push_back(cyc);
      end
    end
  endtask

  initial begin
    int c0;
    int p;
    int r0, r1, r2;
    rst_n = 1'b0;
    key   = 3'b000;
    clear_stats();

    // 1: reset with all keys held, then all three accepted together
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("rst_outputs", 32'({btn, prs, rel, lng, rpt}), 32'd0);
    end
    rst_n = 1'b1;
    clear_stats();
    repeat (9) tick();
    chk("t1_btn_before", 32'(btn), 32'd0);
    tick();
    chk("t1_btn", 32'(btn), 32'b111);
    chk("t1_press", 32'(prs), 32'b111);
    tick();
    chk("t1_press_one_cycle", 32'(prs), 32'd0);
    chk("t1_btn_held", 32'(btn), 32'b111);
    key = 3'b111;
    repeat (12) tick();
    chk("t1_release_count", 32'(n_rel[0] + n_rel[1] + n_rel[2]), 32'd3);
    chk("t1_btn_released", 32'(btn), 32'd0);
    chk("t1_no_long", 32'(n_long[0] + n_long[1] + n_long[2]), 32'd0);

    // 2: 6-cycle glitch on key 0 is rejected
    clear_stats();
    key[0] = 1'b0;
    repeat (6) tick();
    key[0] = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      chk("t2_btn", 32'(btn), 32'd0);
    end
    chk("t2_pulses", 32'(n_press[0] + n_rel[0]), 32'd0);

    // 3: key 1 held 60 cycles
    clear_stats();
    c0 = cyc;
    key[1] = 1'b0;
    repeat (60) tick();
    key[1] = 1'b1;
    repeat (20) tick();
    chk("t3_press_count", 32'(n_press[1]), 32'd1);
    chk("t3_press_time", 32'(t_press[1]), 32'(c0 + 10));
    chk("t3_long_count", 32'(n_long[1]), 32'd1);
    chk("t3_long_time", 32'(t_long[1]), 32'(c0 + 50));
    chk("t3_release_count", 32'(n_rel[1]), 32'd1);
    chk("t3_release_time", 32'(t_rel[1]), 32'(c0 + 70));
    chk("t3_btn_final", 32'(btn), 32'd0);

    // 4: key 2 bounces four times, then settles low
    clear_stats();
    for (int b = 0; b < 4; b++) begin
      key[2] = b[0];
      repeat (3) tick();
    end
    key[2] = 1'b0;
    c0 = cyc;
    repeat (20) tick();
    chk("t4_press_count", 32'(n_press[2]), 32'd1);
    chk("t4_press_time", 32'(t_press[2]), 32'(c0 + 10));
    key[2] = 1'b1;
    repeat (15) tick();
    chk("t4_release_count", 32'(n_rel[2]), 32'd1);
    chk("t4_btn_final", 32'(btn), 32'd0);
    chk("t4_no_long", 32'(n_long[2]), 32'd0);

    // 5: keys 0 and 1 together; key 0 released early
    clear_stats();
    c0 = cyc;
    key = 3'b100;
    repeat (10) tick();
    chk("t5_press_vec", 32'(prs), 32'b011);
    repeat (5) tick();
    key[0] = 1'b1;
    repeat (40) tick();
    key[1] = 1'b1;
    repeat (15) tick();
    chk("t5_release0_time", 32'(t_rel[0]), 32'(c0 + 25));
    chk("t5_long0_count", 32'(n_long[0]), 32'd0);
    chk("t5_long1_count", 32'(n_long[1]), 32'd1);
    chk("t5_long1_time", 32'(t_long[1]), 32'(c0 + 50));
    chk("t5_release1_time", 32'(t_rel[1]), 32'(c0 + 65));
`ifdef BTN_AUTO_REPEAT_EN
    chk("t5_repeat1_count", 32'(n_rep[1]), 32'd1);
`else
    chk("t5_repeat1_count", 32'(n_rep[1]), 32'd0);
`endif

    // 6: key 2 held until release_pulse lands 75 cycles after press_pulse
    clear_stats();
    c0 = cyc;
    p  = c0 + 10;
    key[2] = 1'b0;
    repeat (75) tick();
    key[2] = 1'b1;
    repeat (35) tick();
    chk("t6_press_time", 32'(t_press[2]), 32'(p));
    chk("t6_long_time", 32'(t_long[2]), 32'(p + 40));
    chk("t6_release_time", 32'(t_rel[2]), 32'(p + 75));
    r0 = (rep_q.size() > 0) ? rep_q[0] : -1;
    r1 = (rep_q.size() > 1) ? rep_q[1] : -1;
    r2 = (rep_q.size() > 2) ? rep_q[2] : -1;
`ifdef BTN_AUTO_REPEAT_EN
    chk("t6_repeat_count", 32'(n_rep[2]), 32'd3);
    chk("t6_repeat0_time", 32'(r0), 32'(p + 50));
    chk("t6_repeat1_time", 32'(r1), 32'(p + 60));
    chk("t6_repeat2_time", 32'(r2), 32'(p + 70));
`else
    chk("t6_repeat_count", 32'(n_rep[2]), 32'd0);
    chk("t6_repeat0_time", 32'(r0), 32'hFFFF_FFFF);
`endif
    chk("t6_btn_final", 32'(btn), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
